tick_sched_ctrl: RTL and testbench

- Controller and configurator for the shared clock-divider resource.
- Holds four independent divide-by-N channels, each producing a one-cycle tick enable and a square-wave/duty output.
- Divisors are reprogrammed at runtime through a valid/ready handshake. A new divisor takes effect glitch-free at the channel's next wrap, or immediately on request.
- Sits between the top-level control logic (stopwatch/display sequencing) and every consumer of divided enables.

---
 rtl/tick_sched_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_tick_sched_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl: four independent divide-by-N tick/duty channels sharing one
// runtime configuration port.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   run        1 = channel counters advance, 0 = counters and sq hold, ticks suppressed
//   cfg_valid  configuration request valid (held until accepted)
//   cfg_ready  request can be accepted this cycle
//   cfg_sel    target channel of the request
//   cfg_div    new divisor (0 disables the channel)
//   cfg_now    1 = apply at once and restart the counter, 0 = apply at the next wrap
//   cfg_done   one-cycle pulse after the divisor has been applied
//   tick       per-channel one-cycle enable, period = divisor while run = 1
//   sq         per-channel duty output, high while count < floor(divisor / 2)
//
// Every output comes straight from a flop; nothing combinational reaches a pin.
module tick_sched_ctrl #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DIV0  = 32,
  parameter int unsigned DIV1  = 3,
  parameter int unsigned DIV2  = 200,
  parameter int unsigned DIV3  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_sel,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_now,
  output logic             cfg_done,
  output logic [3:0]       tick,
  output logic [3:0]       sq
);

  localparam int unsigned NumCh = 4;

  typedef enum logic [1:0] {StIdle, StPend, StDone} state_e;

  state_e state_q, state_d;

  // Latched request payload.
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] new_div_q, new_div_d;
  logic             now_q, now_d;

  // Channel state.
  logic [WIDTH-1:0] div_q [NumCh];
  logic [WIDTH-1:0] div_d [NumCh];
  logic [WIDTH-1:0] cnt_q [NumCh];
  logic [WIDTH-1:0] cnt_d [NumCh];
  logic [3:0]       tick_q, tick_d;
  logic [3:0]       sq_q, sq_d;

  logic             cfg_ready_q, cfg_done_q;

  logic [3:0]       wrap;
  logic             apply;

  // A channel wraps on the edge where it is running, enabled and at its last count.
  always_comb begin
    wrap = '0;
    for (int i = 0; i < NumCh; i++) begin
      wrap[i] = run && (div_q[i] != '0) && (cnt_q[i] == div_q[i] - WIDTH'(1));
    end
  end

  // A pending request lands on an immediate request, on a disabled target (there is
  // no wrap to wait for), or on the target's wrap edge.
  assign apply = (state_q == StPend) && (now_q || (div_q[sel_q] == '0) || wrap[sel_q]);

  // Configuration FSM.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    new_div_d = new_div_q;
    now_d     = now_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          sel_d     = cfg_sel;
          new_div_d = cfg_div;
          now_d     = cfg_now;
          state_d   = StPend;
        end
      end
      StPend: begin
        if (apply) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Channel next-state, with the configuration apply layered on the selected channel.
  always_comb begin
    tick_d = '0;
    sq_d   = sq_q;
    for (int i = 0; i < NumCh; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
      if (div_q[i] == '0) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (run) begin
        if (wrap[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
        sq_d[i] = (cnt_d[i] < (div_q[i] >> 1));
      end

      if (apply && (int'(sel_q) == i)) begin
        div_d[i] = new_div_q;
        cnt_d[i] = '0;
        if (now_q || (div_q[i] == '0)) begin
          // Restart: no tick, duty low on the restart edge.
          tick_d[i] = 1'b0;
          sq_d[i]   = 1'b0;
        end else begin
          // Wrap apply keeps the wrap tick; duty follows the new divisor at count 0.
          sq_d[i] = ((new_div_q >> 1) != '0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      new_div_q   <= '0;
      now_q       <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_done_q  <= 1'b0;
      tick_q      <= '0;
      sq_q        <= '0;
      div_q[0]    <= WIDTH'(DIV0);
      div_q[1]    <= WIDTH'(DIV1);
      div_q[2]    <= WIDTH'(DIV2);
      div_q[3]    <= WIDTH'(DIV3);
      for (int i = 0; i < NumCh; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      new_div_q   <= new_div_d;
      now_q       <= now_d;
      // Handshake outputs are registered copies of the next state decode.
      cfg_ready_q <= (state_d == StIdle);
      cfg_done_q  <= (state_d == StDone);
      tick_q      <= tick_d;
      sq_q        <= sq_d;
      for (int i = 0; i < NumCh; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_done  = cfg_done_q;
  assign tick      = tick_q;
  assign sq        = sq_q;

  // The done pulse is always followed by a return to idle.
  done_one_cycle: assert property (@(posedge clk) disable iff (rst) cfg_done |=> !cfg_done);
  ready_done_excl: assert property (@(posedge clk) disable iff (rst) !(cfg_ready && cfg_done));

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Bench for tick_sched_ctrl: directed scenarios plus a randomized run, all checked
// cycle by cycle against a behavioural model of the divider channels and the
// request/apply/done handshake.
module tb_tick_sched_ctrl;

  localparam int W = 27;
  localparam int DEF_DIV [4] = '{32, 3, 200, 0};

  logic         clk = 1'b0;
  logic         rst;
  logic         run;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [1:0]   cfg_sel;
  logic [W-1:0] cfg_div;
  logic         cfg_now;
  logic         cfg_done;
  logic [3:0]   tick;
  logic [3:0]   sq;

  int total = 0;
  int bad   = 0;

  // Model state.
  int       m_div [4];
  int       m_cnt [4];
  bit [3:0] m_tick, m_sq;
  bit       m_ready, m_done;
  int       m_phase;  // 0 idle, 1 pending, 2 done
  int       p_sel, p_div;
  bit       p_now;
  int       edge_n = 0;

  tick_sched_ctrl #(
    .WIDTH(W), .DIV0(32), .DIV1(3), .DIV2(200), .DIV3(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel  (cfg_sel),
    .cfg_div  (cfg_div),
    .cfg_now  (cfg_now),
    .cfg_done (cfg_done),
    .tick     (tick),
    .sq       (sq)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int nd [4];
    int nc [4];
    bit [3:0] nt, ns;
    bit apply;
    edge_n++;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_div[i] = DEF_DIV[i];
        m_cnt[i] = 0;
      end
      m_tick = '0; m_sq = '0; m_phase = 0; m_ready = 1'b1; m_done = 1'b0;
    end else begin
      apply = 1'b0;
      if (m_phase == 1)
        apply = p_now || (m_div[p_sel] == 0) || (run && (m_cnt[p_sel] == m_div[p_sel] - 1));
      for (int i = 0; i < 4; i++) begin
        nd[i] = m_div[i];
        nt[i] = 1'b0;
        if (m_div[i] == 0) begin
          nc[i] = 0; ns[i] = 1'b0;
        end else if (!run) begin
          nc[i] = m_cnt[i]; ns[i] = m_sq[i];
        end else begin
          nc[i] = (m_cnt[i] + 1) % m_div[i];
          nt[i] = (nc[i] == 0);
          ns[i] = (nc[i] < m_div[i] / 2);
        end
        if (apply && i == p_sel) begin
          nd[i] = p_div;
          nc[i] = 0;
          if (p_now || m_div[i] == 0) begin
            nt[i] = 1'b0; ns[i] = 1'b0;
          end else begin
            ns[i] = (p_div / 2) > 0;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        m_div[i] = nd[i];
        m_cnt[i] = nc[i];
      end
      m_tick = nt; m_sq = ns;
      case (m_phase)
        0: if (cfg_valid) begin
             p_sel = int'(cfg_sel); p_div = int'(cfg_div); p_now = cfg_now; m_phase = 1;
           end
        1: if (apply) m_phase = 2;
        default: m_phase = 0;
      endcase
      m_ready = (m_phase == 0);
      m_done  = (m_phase == 2);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_sel = '0; cfg_div = '0; cfg_now = 1'b0;
    repeat (3) step();
    total++;
    if ({tick, sq, cfg_ready, cfg_done} !== 10'b0000_0000_1_0) begin
      bad++;
      $display("FAIL reset got tick=%b sq=%b rdy=%b done=%b want 0000 0000 1 0",
               tick, sq, cfg_ready, cfg_done);
    end
    rst = 1'b0;
    step();
    total++;
    if ({tick, sq, cfg_ready, cfg_done} !== {m_tick, m_sq, m_ready, m_done}) begin
      bad++;
      $display("FAIL reset_idle got %b %b %b %b want %b %b %b %b",
               tick, sq, cfg_ready, cfg_done, m_tick, m_sq, m_ready, m_done);
    end
  endtask

  task automatic test_free_run();
    int first0 = -1;
    int n0 = 0, n1 = 0, n2 = 0, n3 = 0, h0 = 0, h1 = 0, h3 = 0;
    run = 1'b1;
    for (int e = 1; e <= 800; e++) begin
      step();
      total++;
      if ({tick, sq, cfg_ready, cfg_done} !== {m_tick, m_sq, m_ready, m_done}) begin
        bad++;
        $display("FAIL free_run@%0d got %b %b %b %b want %b %b %b %b", e,
                 tick, sq, cfg_ready, cfg_done, m_tick, m_sq, m_ready, m_done);
      end
      if (tick[0] === 1'b1 && first0 < 0) first0 = e;
      n0 += int'(tick[0]); n1 += int'(tick[1]); n2 += int'(tick[2]); n3 += int'(tick[3]);
      h0 += int'(sq[0]); h1 += int'(sq[1]); h3 += int'(sq[3]);
    end
    total++;
    if (first0 != 32) begin
      bad++; $display("FAIL first_tick0 got=%0d want=32", first0);
    end
    total++;
    if ({n0, n1, n2, n3} != {32'd25, 32'd266, 32'd4, 32'd0}) begin
      bad++; $display("FAIL tick_counts got=%0d/%0d/%0d/%0d want=25/266/4/0", n0, n1, n2, n3);
    end
    total++;
    if ({h0, h1, h3} != {32'd400, 32'd266, 32'd0}) begin
      bad++; $display("FAIL sq_high_counts got=%0d/%0d/%0d want=400/266/0", h0, h1, h3);
    end
  endtask

  task automatic test_deferred();
    int acc_e, done_e = -1;
    int t0 [$];
    for (int k = 0; k < 64 && m_cnt[0] != 5; k++) step();
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = W'(8); cfg_now = 1'b0;
    step();
    acc_e = edge_n;
    cfg_valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      total++;
      if ({tick, sq, cfg_ready, cfg_done} !== {m_tick, m_sq, m_ready, m_done}) begin
        bad++;
        $display("FAIL deferred@%0d got %b %b %b %b want %b %b %b %b", edge_n,
                 tick, sq, cfg_ready, cfg_done, m_tick, m_sq, m_ready, m_done);
      end
      if (cfg_done === 1'b1 && done_e < 0) done_e = edge_n;
      if (tick[0] === 1'b1) t0.push_back(edge_n);
    end
    total++;
    if (done_e != acc_e + 26) begin
      bad++; $display("FAIL deferred_done got=%0d want=%0d", done_e - acc_e, 26);
    end
    total++;
    if (t0.size() < 3 || t0[0] != acc_e + 26 || t0[1] - t0[0] != 8 || t0[2] - t0[1] != 8) begin
      bad++; $display("FAIL deferred_ticks got count=%0d want wrap at +26 then period 8", t0.size());
    end
  endtask

  task automatic test_immediate();
    int acc_e, done_e = -1, rdy_e = -1, t2 = -1;
    for (int k = 0; k < 250 && (m_cnt[2] < 10 || m_cnt[2] > 150); k++) step();
    cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_div = W'(4); cfg_now = 1'b1;
    step();
    acc_e = edge_n;
    cfg_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      total++;
      if ({tick, sq, cfg_ready, cfg_done} !== {m_tick, m_sq, m_ready, m_done}) begin
        bad++;
        $display("FAIL immediate@%0d got %b %b %b %b want %b %b %b %b", edge_n,
                 tick, sq, cfg_ready, cfg_done, m_tick, m_sq, m_ready, m_done);
      end
      if (cfg_done === 1'b1 && done_e < 0) done_e = edge_n;
      if (cfg_ready === 1'b1 && rdy_e < 0) rdy_e = edge_n;
      if (tick[2] === 1'b1 && t2 < 0) t2 = edge_n;
    end
    total++;
    // Ready is back after acc+2, so the next request can be taken at acc+3.
    if (done_e != acc_e + 1 || rdy_e != acc_e + 2) begin
      bad++; $display("FAIL immediate_handshake got done=+%0d rdy=+%0d want +1/+2",
                      done_e - acc_e, rdy_e - acc_e);
    end
    total++;
    if (t2 != acc_e + 5) begin
      bad++; $display("FAIL immediate_tick got=+%0d want=+5", t2 - acc_e);
    end
  endtask

  task automatic test_enable();
    int acc_e, done_e = -1, t3 = -1, h3 = 0, late = 0;
    cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_div = W'(5); cfg_now = 1'b0;
    step();
    acc_e = edge_n;
    cfg_valid = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      total++;
      if ({tick, sq, cfg_ready, cfg_done} !== {m_tick, m_sq, m_ready, m_done}) begin
        bad++;
        $display("FAIL enable@%0d got %b %b %b %b want %b %b %b %b", edge_n,
                 tick, sq, cfg_ready, cfg_done, m_tick, m_sq, m_ready, m_done);
      end
      if (cfg_done === 1'b1 && done_e < 0) done_e = edge_n;
      if (tick[3] === 1'b1 && t3 < 0) t3 = edge_n;
      if (k >= 2 && k <= 31) h3 += int'(sq[3]);
    end
    total++;
    if (done_e != acc_e + 1 || t3 != acc_e + 6 || h3 != 12) begin
      bad++; $display("FAIL enable_ch3 got done=+%0d tick=+%0d sqhi=%0d want +1/+6/12",
                      done_e - acc_e, t3 - acc_e, h3);
    end
    cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_div = '0; cfg_now = 1'b0;
    step();
    cfg_valid = 1'b0;
    done_e = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if ({tick, sq, cfg_ready, cfg_done} !== {m_tick, m_sq, m_ready, m_done}) begin
        bad++;
        $display("FAIL disable@%0d got %b %b %b %b want %b %b %b %b", edge_n,
                 tick, sq, cfg_ready, cfg_done, m_tick, m_sq, m_ready, m_done);
      end
      if (cfg_done === 1'b1 && done_e < 0) begin
        done_e = edge_n;
        total++;
        if (tick[3] !== 1'b1) begin
          bad++; $display("FAIL disable_wrap_tick got=%b want=1", tick[3]);
        end
      end else if (done_e >= 0 && (tick[3] !== 1'b0 || sq[3] !== 1'b0)) begin
        late++;
      end
    end
    total++;
    if (done_e < 0 || late != 0) begin
      bad++; $display("FAIL disable_ch3 got done=%0d active_after=%0d want done and 0", done_e, late);
    end
  endtask

  task automatic test_pause();
    int dn = 0, tk = 0, c0, done_e = -1;
    run = 1'b0;
    cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_div = W'(16); cfg_now = 1'b0;
    step();
    cfg_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 5) begin
        cfg_valid = 1'b1; cfg_sel = 2'd1; cfg_div = W'(7); cfg_now = 1'b1;
      end
      step();
      total++;
      if ({tick, sq, cfg_ready, cfg_done} !== {m_tick, m_sq, m_ready, m_done}) begin
        bad++;
        $display("FAIL pause@%0d got %b %b %b %b want %b %b %b %b", edge_n,
                 tick, sq, cfg_ready, cfg_done, m_tick, m_sq, m_ready, m_done);
      end
      dn += int'(cfg_done); tk += int'(tick != 4'b0);
    end
    total++;
    if (dn != 0 || tk != 0) begin
      bad++; $display("FAIL pause_hold got done=%0d ticks=%0d want 0/0", dn, tk);
    end
    cfg_valid = 1'b0; run = 1'b1;
    c0 = m_cnt[0];
    for (int e = 1; e <= 20; e++) begin
      step();
      total++;
      if ({tick, sq, cfg_ready, cfg_done} !== {m_tick, m_sq, m_ready, m_done}) begin
        bad++;
        $display("FAIL resume@%0d got %b %b %b %b want %b %b %b %b", edge_n,
                 tick, sq, cfg_ready, cfg_done, m_tick, m_sq, m_ready, m_done);
      end
      if (cfg_done === 1'b1) begin
        dn++;
        if (done_e < 0) done_e = e;
      end
    end
    total++;
    if (dn != 1 || done_e != 8 - c0) begin
      bad++; $display("FAIL resume_apply got dones=%0d at=%0d want 1 at %0d", dn, done_e, 8 - c0);
    end
  endtask

  task automatic test_reset_pend();
    int f0 = -1, f1 = -1, f2 = -1, dn = 0;
    run = 1'b0;
    cfg_valid = 1'b1; cfg_sel = 2'd2; cfg_div = W'(9); cfg_now = 1'b0;
    step();
    cfg_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({tick, sq, cfg_ready, cfg_done} !== 10'b0000_0000_1_0) begin
      bad++;
      $display("FAIL reset_pend got tick=%b sq=%b rdy=%b done=%b want 0000 0000 1 0",
               tick, sq, cfg_ready, cfg_done);
    end
    run = 1'b1;
    for (int e = 1; e <= 210; e++) begin
      step();
      total++;
      if ({tick, sq, cfg_ready, cfg_done} !== {m_tick, m_sq, m_ready, m_done}) begin
        bad++;
        $display("FAIL post_reset@%0d got %b %b %b %b want %b %b %b %b", e,
                 tick, sq, cfg_ready, cfg_done, m_tick, m_sq, m_ready, m_done);
      end
      if (tick[0] === 1'b1 && f0 < 0) f0 = e;
      if (tick[1] === 1'b1 && f1 < 0) f1 = e;
      if (tick[2] === 1'b1 && f2 < 0) f2 = e;
      dn += int'(cfg_done);
    end
    total++;
    if (f0 != 32 || f1 != 3 || f2 != 200 || dn != 0) begin
      bad++; $display("FAIL post_reset_periods got %0d/%0d/%0d done=%0d want 32/3/200 done=0",
                      f0, f1, f2, dn);
    end
  endtask

  task automatic test_random();
    bit acc;
    for (int k = 0; k < 2000; k++) begin
      run = ($urandom_range(9) != 0);
      rst = ($urandom_range(399) == 0);
      if (!cfg_valid && $urandom_range(7) == 0) begin
        cfg_valid = 1'b1;
        cfg_sel   = 2'($urandom_range(3));
        cfg_div   = W'($urandom_range(12));
        cfg_now   = 1'($urandom_range(1));
      end
      acc = cfg_valid && m_ready && !rst;
      step();
      if (acc) cfg_valid = 1'b0;
      total++;
      if ({tick, sq, cfg_ready, cfg_done} !== {m_tick, m_sq, m_ready, m_done}) begin
        bad++;
        $display("FAIL random@%0d got %b %b %b %b want %b %b %b %b", edge_n,
                 tick, sq, cfg_ready, cfg_done, m_tick, m_sq, m_ready, m_done);
      end
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_deferred();
    test_immediate();
    test_enable();
    test_pause();
    test_reset_pend();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
